pc_pilha: RTL

Parametrised program counter with an integrated return-address stack. It is the next-generation fetch-address generator for the processor core. It adds configurable width, increment step and reset vector, PC-relative branches, and call/return support with overflow/underflow detection. It sits in front of instruction memory; `saida` is the fetch address for the current cycle.

---
 rtl/pc_pkg.sv | 43 ++++
 rtl/pilha_retorno.sv | 70 +++++++
 rtl/pc_pilha.sv | 105 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and the action decoder for the program counter with return stack.
package pc_pkg;

    // One action per cycle; declaration order mirrors decoding priority.
    typedef enum logic [2:0] {
        RESET,
        RETORNO,
        CHAMADA,
        JUMP,
        DESVIO,
        HALT,
        INCREMENTA
    } op_pc_t;

    // Fixed-priority selection: lower-priority requests in the same cycle are dropped.
    function automatic op_pc_t decodifica_op(
        input logic reseta_n,
        input logic retorno,
        input logic chamada,
        input logic jump,
        input logic desvio,
        input logic halt
    );
        op_pc_t op;
        if (!reseta_n) begin
            op = RESET;
        end else if (retorno) begin
            op = RETORNO;
        end else if (chamada) begin
            op = CHAMADA;
        end else if (jump) begin
            op = JUMP;
        end else if (desvio) begin
            op = DESVIO;
        end else if (halt) begin
            op = HALT;
        end else begin
            op = INCREMENTA;
        end
        return op;
    endfunction

endpackage

// File: rtl/pilha_retorno.sv
// Circular LIFO of return addresses. On overflow the push still happens and
// overwrites the oldest entry, while the level saturates at PROFUNDIDADE.
module pilha_retorno #(
    parameter int unsigned LARGURA      = 32,
    parameter int unsigned PROFUNDIDADE = 8
) (
    input  logic                                clock,
    input  logic                                reseta_n,
    input  logic                                push,
    input  logic                                pop,
    input  logic [LARGURA-1:0]                  dado,
    output logic [LARGURA-1:0]                  topo,
    output logic [$clog2(PROFUNDIDADE+1)-1:0]   nivel,
    output logic                                cheia,
    output logic                                vazia
);
    import pc_pkg::*;

    localparam int unsigned LP = $clog2(PROFUNDIDADE);
    localparam int unsigned LN = $clog2(PROFUNDIDADE + 1);

    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    // ptr_q points at the next free slot; the top lives at ptr_q - 1.
    logic [LP-1:0]      ptr_q, ptr_d;
    logic [LN-1:0]      nivel_q, nivel_d;
    logic [LP-1:0]      ptr_topo;
    logic               pop_ok;

    assign ptr_topo = ptr_q - LP'(1);
    assign topo     = mem[ptr_topo];
    assign nivel    = nivel_q;
    assign cheia    = (nivel_q == LN'(PROFUNDIDADE));
    assign vazia    = (nivel_q == '0);
    // A pop of an empty stack must not move the pointer.
    assign pop_ok   = pop && !vazia;

    // Next pointer and level for push/pop; power-of-two depth makes the wrap free.
    always_comb begin
        ptr_d   = ptr_q;
        nivel_d = nivel_q;
        if (push) begin
            ptr_d = ptr_q + LP'(1);
            if (!cheia) begin
                nivel_d = nivel_q + LN'(1);
            end
        end else if (pop_ok) begin
            ptr_d   = ptr_q - LP'(1);
            nivel_d = nivel_q - LN'(1);
        end
    end

    // Pointer and level registers; reset clears them but leaves the RAM alone.
    always_ff @(posedge clock) begin
        if (!reseta_n) begin
            ptr_q   <= '0;
            nivel_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            nivel_q <= nivel_d;
        end
    end

    // Stack RAM write; written value is readable as topo right after the edge.
    always_ff @(posedge clock) begin
        if (push && reseta_n) begin
            mem[ptr_q] <= dado;
        end
    end

endmodule

// File: rtl/pc_pilha.sv
// Fetch-address generator: program counter with branches, jumps and a
// return-address stack for call/return. saida is the current fetch address.
module pc_pilha #(
    parameter int unsigned       LARGURA      = 32,
    parameter int unsigned       PASSO        = 1,
    parameter logic [LARGURA-1:0] VALOR_RESET = '0,
    parameter int unsigned       PROFUNDIDADE = 8
) (
    input  logic                                clock,
    input  logic                                reseta_n,
    input  logic                                halt,
    input  logic                                jump,
    input  logic                                desvio,
    input  logic                                chamada,
    input  logic                                retorno,
    input  logic [LARGURA-1:0]                  endereco,
    input  logic [LARGURA-1:0]                  deslocamento,
    output logic [LARGURA-1:0]                  saida,
    output logic                                pilha_vazia,
    output logic                                pilha_cheia,
    output logic [$clog2(PROFUNDIDADE+1)-1:0]   nivel,
    output logic                                erro_pilha
);
    import pc_pkg::*;

    localparam logic [LARGURA-1:0] PASSO_V = LARGURA'(PASSO);

    op_pc_t             op;
    logic [LARGURA-1:0] saida_q, saida_d;
    logic               erro_q, erro_d;
    logic [LARGURA-1:0] proximo;
    logic [LARGURA-1:0] topo;
    logic               empilha;
    logic               desempilha;
    logic               cheia;
    logic               vazia;

    assign proximo = saida_q + PASSO_V;

    pilha_retorno #(
        .LARGURA      (LARGURA),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_pilha (
        .clock    (clock),
        .reseta_n (reseta_n),
        .push     (empilha),
        .pop      (desempilha),
        .dado     (proximo),
        .topo     (topo),
        .nivel    (nivel),
        .cheia    (cheia),
        .vazia    (vazia)
    );

    // Decode the single winning action and compute next PC and error flag.
    always_comb begin
        op         = decodifica_op(reseta_n, retorno, chamada, jump, desvio, halt);
        empilha    = (op == CHAMADA);
        desempilha = (op == RETORNO) && !vazia;
        saida_d    = saida_q;
        erro_d     = erro_q;
        case (op)
            RESET: begin
                saida_d = VALOR_RESET;
                erro_d  = 1'b0;
            end
            RETORNO: begin
                if (vazia) begin
                    erro_d = 1'b1;
                end else begin
                    saida_d = topo;
                end
            end
            CHAMADA: begin
                saida_d = endereco;
                if (cheia) begin
                    erro_d = 1'b1;
                end
            end
            JUMP:       saida_d = endereco;
            // Relative to the current PC, not the sequential successor.
            DESVIO:     saida_d = saida_q + deslocamento;
            HALT:       saida_d = saida_q;
            INCREMENTA: saida_d = proximo;
            default:    saida_d = saida_q;
        endcase
    end

    // PC and sticky error registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reseta_n) begin
            saida_q <= VALOR_RESET;
            erro_q  <= 1'b0;
        end else begin
            saida_q <= saida_d;
            erro_q  <= erro_d;
        end
    end

    assign saida       = saida_q;
    assign erro_pilha  = erro_q;
    assign pilha_cheia = cheia;
    assign pilha_vazia = vazia;

endmodule
